// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: ALU/load-return arbitration with starvation guard, registered register-file write port,
// long-latency busy scoreboard with rs/rt hazard output. Optional write-to-read forwarding under macro WB_BYPASS_EN.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef REGISTER_FILE_SIZE
`define REGISTER_FILE_SIZE 16
`endif

module regfile_wb_ctrl #(
    parameter int DATA_W     = `GPR_WIDTH,
    parameter int NREGS      = `REGISTER_FILE_SIZE,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] rf_data_rs,
    input  logic [DATA_W-1:0] rf_data_rt,
    output logic [DATA_W-1:0] op_rs,
    output logic [DATA_W-1:0] op_rt,
    output logic              hazard,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic              err_addr
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

    logic [SW-1:0]     starve, starve_next;
    logic              starved;
    logic              accept_alu, accept_mem, accept, addr_ok;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [NREGS-1:0]  busy, busy_next;
    logic              busy_rs, busy_rt;

    // The load return loses to the ALU until it has been refused STARVE_MAX cycles in a row.
    always_comb begin
        accept_alu  = 1'b0;
        accept_mem  = 1'b0;
        alu_stall   = 1'b0;
        starved     = (starve == SW'(STARVE_MAX));
        if (alu_valid && mem_valid) begin
            if (starved) begin
                accept_mem = 1'b1;
                alu_stall  = 1'b1;
            end else begin
                accept_alu = 1'b1;
            end
        end else if (alu_valid) begin
            accept_alu = 1'b1;
        end else if (mem_valid) begin
            accept_mem = 1'b1;
        end
        mem_ready = accept_mem;
        accept    = accept_alu | accept_mem;

        starve_next = starve;
        if (!mem_valid || accept_mem) begin
            starve_next = '0;
        end else if (!starved) begin
            starve_next = starve + SW'(1);
        end

        sel_rd   = accept_mem ? mem_rd : alu_rd;
        sel_data = accept_mem ? mem_data : alu_data;
        addr_ok  = ({1'b0, sel_rd} < NREGS_W);
    end

    // Set is applied after clear so an issue in the same cycle as the returning load keeps the register busy.
    always_comb begin
        busy_next = busy;
        busy_rs   = 1'b0;
        busy_rt   = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (accept_mem && mem_rd == ADDR_W'(i)) begin
                busy_next[i] = 1'b0;
            end
            if (issue_valid && issue_long && issue_rd == ADDR_W'(i)) begin
                busy_next[i] = 1'b1;
            end
            if (rs == ADDR_W'(i)) begin
                busy_rs = busy[i];
            end
            if (rt == ADDR_W'(i)) begin
                busy_rt = busy[i];
            end
        end
        hazard = busy_rs | busy_rt;
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        op_rs = (rf_en && rf_rd == rs) ? rf_data : rf_data_rs;
        op_rt = (rf_en && rf_rd == rt) ? rf_data : rf_data_rt;
`else
        op_rs = rf_data_rs;
        op_rt = rf_data_rt;
`endif
    end

    // Address and data only move on a legal write so rf_data keeps its last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve   <= '0;
            busy     <= '0;
            rf_en    <= 1'b0;
            rf_rd    <= '0;
            rf_data  <= '0;
            err_addr <= 1'b0;
        end else begin
            starve   <= starve_next;
            busy     <= busy_next;
            rf_en    <= accept & addr_ok;
            err_addr <= accept & ~addr_ok;
            if (accept && addr_ok) begin
                rf_rd   <= sel_rd;
                rf_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl; expected values are hand-computed constants.
// Define WB_BYPASS_EN for both bench and RTL to check the forwarding build.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rf_data_rs;
    logic [31:0] rf_data_rt;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        hazard;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        err_addr;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs(rs), .rt(rt), .rf_data_rs(rf_data_rs), .rf_data_rt(rf_data_rt),
        .op_rs(op_rs), .op_rt(op_rt), .hazard(hazard),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
    endtask

    task automatic issue(input logic v, input logic lng, input logic [4:0] rd);
        issue_valid = v;
        issue_long  = lng;
        issue_rd    = rd;
    endtask

    initial begin
        // reset with random inputs
        rst = 1'b1;
        applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        issue(1'($urandom), 1'($urandom), 5'($urandom));
        rs = 5'($urandom); rt = 5'($urandom);
        rf_data_rs = $urandom; rf_data_rt = $urandom;
        tick();
        tick();
        mem_valid = 1'b0;
        rs = 5'd7; rt = 5'd3;
        #1;
        checkOutput("reset_rf_en", 32'(rf_en), 32'd0);
        checkOutput("reset_rf_data", rf_data, 32'd0);
        checkOutput("reset_err_addr", 32'(err_addr), 32'd0);
        checkOutput("reset_hazard", 32'(hazard), 32'd0);
        checkOutput("reset_mem_ready", 32'(mem_ready), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(1'b0, 1'b0, 5'd0);
        rf_data_rs = 32'd0; rf_data_rt = 32'd0;
        rst = 1'b0;
        tick();

        // single ALU write
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("alu_only_stall", 32'(alu_stall), 32'd0);
        checkOutput("alu_only_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        checkOutput("alu_wr_en", 32'(rf_en), 32'd1);
        checkOutput("alu_wr_rd", 32'(rf_rd), 32'd3);
        checkOutput("alu_wr_data", rf_data, 32'hDEADBEEF);
        tick();
        checkOutput("alu_wr_en_drop", 32'(rf_en), 32'd0);
        checkOutput("alu_wr_data_hold", rf_data, 32'hDEADBEEF);

        // conflict: ALU wins four times, then the load return is forced through
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'd5, 32'h11);
            #1;
            checkOutput($sformatf("conflict_ready_%0d", k), 32'(mem_ready), 32'd0);
            checkOutput($sformatf("conflict_stall_%0d", k), 32'(alu_stall), 32'd0);
            tick();
            checkOutput($sformatf("conflict_data_%0d", k), rf_data, 32'h100 + 32'(k));
        end
        #1;
        checkOutput("starved_ready", 32'(mem_ready), 32'd1);
        checkOutput("starved_stall", 32'(alu_stall), 32'd1);
        tick();
        checkOutput("starved_en", 32'(rf_en), 32'd1);
        checkOutput("starved_rd", 32'(rf_rd), 32'd5);
        checkOutput("starved_data", rf_data, 32'h11);
        #1;
        checkOutput("after_mem_ready", 32'(mem_ready), 32'd0);

        // dropping mem_valid restarts the starvation count
        tick();
        tick();
        mem_valid = 1'b0;
        tick();
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("starve_clear_ready_%0d", k), 32'(mem_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // scoreboard
        issue(1'b1, 1'b1, 5'd7);
        tick();
        issue(1'b0, 1'b0, 5'd0);
        rs = 5'd7; rt = 5'd0;
        #1;
        checkOutput("hazard_rs", 32'(hazard), 32'd1);
        rs = 5'd0; rt = 5'd7;
        #1;
        checkOutput("hazard_rt", 32'(hazard), 32'd1);
        rs = 5'd20; rt = 5'd20;
        #1;
        checkOutput("hazard_oob", 32'(hazard), 32'd0);
        rs = 5'd7; rt = 5'd0;
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'd0);
        tick();
        alu_valid = 1'b0;
        #1;
        checkOutput("hazard_alu_no_clear", 32'(hazard), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        #1;
        checkOutput("sb_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        #1;
        checkOutput("hazard_cleared", 32'(hazard), 32'd0);
        checkOutput("sb_wr_data", rf_data, 32'h77);
        issue(1'b1, 1'b1, 5'd7);
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        issue(1'b0, 1'b0, 5'd0);
        #1;
        checkOutput("hazard_set_wins", 32'(hazard), 32'd1);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        #1;
        checkOutput("hazard_final_clear", 32'(hazard), 32'd0);
        issue(1'b1, 1'b0, 5'd8);
        rs = 5'd8;
        tick();
        issue(1'b0, 1'b0, 5'd0);
        #1;
        checkOutput("hazard_short_issue", 32'(hazard), 32'd0);

        // out-of-range destination
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hBAD);
        #1;
        checkOutput("bad_addr_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        checkOutput("bad_addr_en", 32'(rf_en), 32'd0);
        checkOutput("bad_addr_err", 32'(err_addr), 32'd1);
        checkOutput("bad_addr_data_hold", rf_data, 32'h77);
        tick();
        checkOutput("bad_addr_err_pulse", 32'(err_addr), 32'd0);

        // register 0 is an ordinary register
        applyStimulus(1'b1, 5'd0, 32'hA5, 1'b0, 5'd0, 32'd0);
        tick();
        alu_valid = 1'b0;
        checkOutput("r0_en", 32'(rf_en), 32'd1);
        checkOutput("r0_rd", 32'(rf_rd), 32'd0);
        checkOutput("r0_data", rf_data, 32'hA5);

        // operand forwarding
        applyStimulus(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 32'd0);
        tick();
        alu_valid = 1'b0;
        rs = 5'd2; rf_data_rs = 32'h0;
        rt = 5'd2; rf_data_rt = 32'h33;
        #1;
        checkOutput("bypass_rs", op_rs, BYP ? 32'h55 : 32'h0);
        checkOutput("bypass_rt", op_rt, BYP ? 32'h55 : 32'h33);
        rs = 5'd4; rf_data_rs = 32'h99;
        #1;
        checkOutput("bypass_other_rs", op_rs, 32'h99);
        tick();
        rs = 5'd2; rf_data_rs = 32'h0;
        #1;
        checkOutput("bypass_idle_rs", op_rs, 32'h0);

        // reset mid-operation discards the in-flight write and the scoreboard
        issue(1'b1, 1'b1, 5'd9);
        tick();
        issue(1'b0, 1'b0, 5'd0);
        rs = 5'd9;
        #1;
        checkOutput("mid_reset_busy", 32'(hazard), 32'd1);
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_hazard", 32'(hazard), 32'd0);
        tick();
        checkOutput("mid_reset_en", 32'(rf_en), 32'd0);
        checkOutput("mid_reset_data", rf_data, 32'd0);
        rst = 1'b0;
        alu_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller that drives the register file write port (en/rd/data) and tracks pending long-latency writes.
- Arbitrates each cycle between the single-cycle ALU result path and the memory load-return path (valid/ready), and registers the selected write.
- Keeps a busy scoreboard and gives decode an rs/rt hazard indication.
- Sits between the EX/MEM stages and the register file; its rf_* outputs connect directly to the register file en/rd/data inputs.

Parameters:
DATA_W, `GPR_WIDTH (32), data width of a write
NREGS, `REGISTER_FILE_SIZE (16), number of architectural registers
ADDR_W, 5, register address width
STARVE_MAX, 4, consecutive cycles the memory return may be refused before it gets priority

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_stall  out  1  ALU result refused this cycle; EX must hold
mem_valid  in  1  load-return valid
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load return accepted this cycle
issue_valid  in  1  instruction issued this cycle
issue_long  in  1  issued instruction writes via the memory path
issue_rd  in  ADDR_W  destination of the issued instruction
rs  in  ADDR_W  decode source address A
rt  in  ADDR_W  decode source address B
rf_data_rs  in  DATA_W  register file read data for rs
rf_data_rt  in  DATA_W  register file read data for rt
op_rs  out  DATA_W  operand A to decode
op_rt  out  DATA_W  operand B to decode
hazard  out  1  rs or rt has a pending long write
rf_en  out  1  register file write enable
rf_rd  out  ADDR_W  register file write address
rf_data  out  DATA_W  register file write data
err_addr  out  1  one-cycle pulse: an accepted write had an address >= NREGS

Behaviour:
- Reset: rf_en=0, rf_rd=0, rf_data=0, err_addr=0, busy=0, starve counter=0. Reset asserted mid-operation discards any in-flight write.
- Arbitration (combinational) with starve counter S:
  - Only alu_valid: accept ALU. alu_stall=0, mem_ready=0.
  - Only mem_valid: accept MEM. mem_ready=1.
  - Both valid and S<STARVE_MAX: accept ALU, mem_ready=0. S increments and saturates at STARVE_MAX.
  - Both valid and S==STARVE_MAX: accept MEM, mem_ready=1, alu_stall=1.
  - S clears on any MEM acceptance, and on any cycle with mem_valid=0.
- Latency: the accepted write appears on rf_en/rf_rd/rf_data on the next rising edge, held for exactly one cycle. rf_en=0 in cycles with no acceptance. rf_data holds its last value when rf_en=0.
- Address check:
  - An accepted write with address >= NREGS is consumed (handshake completes) but gives rf_en=0 and err_addr=1 in the following cycle.
  - Register 0 is an ordinary register and is written normally.
- Scoreboard (busy[NREGS-1:0]):
  - issue_valid & issue_long & issue_rd<NREGS sets busy[issue_rd] at the clock edge.
  - Accepted MEM write clears busy[mem_rd].
  - Set and clear of the same register in one cycle: set wins.
  - ALU writes never touch busy.
- hazard = busy[rs] | busy[rt]. Addresses >= NREGS read as not busy. Combinational from the current busy state.
- op_rs/op_rt: see the optional feature below.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: if rf_en=1 and rf_rd==rs, op_rs=rf_data, otherwise op_rs=rf_data_rs. op_rt is handled the same way. This covers the write happening in the same cycle as the read.
- Undefined: op_rs=rf_data_rs and op_rt=rf_data_rt (pure pass-through). Decode must stall one cycle on a read-after-write to the same address.

Test Plan:
- Reset: hold rst for 2 cycles with random inputs -> rf_en=0, rf_data=0, hazard=0, mem_ready=0 while mem_valid=0.
- ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> next cycle rf_en=1, rf_rd=3, rf_data=0xDEADBEEF; the cycle after that rf_en=0.
- Conflict and starvation: alu_valid=1 and mem_valid=1 (mem_rd=5, mem_data=0x11) held constant -> ALU accepted for 4 cycles with mem_ready=0; 5th cycle mem_ready=1 and alu_stall=1; next cycle rf_rd=5, rf_data=0x11.
- Scoreboard: issue_long with issue_rd=7; then rs=7 -> hazard=1. MEM write to reg 7 accepted -> hazard=0 one cycle later. Issue to reg 7 in the same cycle as the clearing write -> hazard stays 1.
- Bad address: mem_valid=1, mem_rd=20 -> mem_ready=1; next cycle rf_en=0 and err_addr=1 for one cycle.
- Bypass (WB_BYPASS_EN defined): rf_en=1, rf_rd=2, rf_data=0x55, rs=2, rf_data_rs=0x00 -> op_rs=0x55. With the macro undefined -> op_rs=0x00.
